// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the memory-stage responder.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP,
    ERR
  } mem_state_t;

  localparam int WORD_BYTES = 4;
  localparam int MAX_WAIT   = 15;
  localparam int OFF_W      = $clog2(WORD_BYTES);
  localparam int CNT_W      = $clog2(MAX_WAIT + 1);

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port word RAM, synchronous read with one-cycle latency.
module data_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] widx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) r_mem[widx] <= wdata;
    rdata <= r_mem[widx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage responder: wait-stated load/store access to the data RAM.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_w_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        stall
);

  localparam logic [CNT_W-1:0] WAIT_INIT =
    CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  mem_state_t r_state;
  mem_state_t w_next;

  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic              r_we;

  logic        w_legal;
  logic        w_accept;
  logic        w_ram_we;
  logic [31:0] w_ram_rdata;

  assign w_legal  = ~(|addr[OFF_W-1:0]) & ~(|addr[31:ADDR_W+OFF_W]);
  assign w_accept = req_valid && (r_state == IDLE);
  assign w_ram_we = (r_state == ACCESS) && r_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (!w_legal)              w_next = ERR;
          else if (WAIT_CYCLES == 0) w_next = ACCESS;
          else                       w_next = WAIT;
        end
      end
      WAIT:    if (r_cnt == '0) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rdata     = '0;
    addr_err  = 1'b0;
    stall     = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid && w_legal;
      end
      WAIT:   stall = 1'b1;
      ACCESS: stall = 1'b1;
      RESP: begin
        rsp_valid = 1'b1;
        rdata     = r_we ? '0 : w_ram_rdata;
      end
      ERR: begin
        rsp_valid = 1'b1;
        addr_err  = 1'b1;
      end
      default: ;
    endcase
  end

  // Request fields are captured on accept and held until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= WAIT_INIT;
      r_idx   <= addr[ADDR_W+OFF_W-1:OFF_W];
      r_wdata <= wdata;
      r_we    <= mem_w_en;
    end else if (r_state == WAIT) begin
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  data_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (w_ram_we),
    .widx (r_idx),
    .wdata(r_wdata),
    .rdata(w_ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table, corner sequences, random vs model.
module tb_data_mem_responder;

  localparam int W = 2;

  logic        clk;
  logic        rst;

  logic        a_req_valid, a_req_ready, a_mem_w_en;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        a_rsp_valid, a_addr_err, a_stall;

  logic        z_req_valid, z_req_ready, z_mem_w_en;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic        z_rsp_valid, z_addr_err, z_stall;

  int checks;
  int failures;

  logic [31:0] m [int];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          eerr;
    logic [31:0] erd;
  } vec_t;

  vec_t vt [12];

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(a_req_valid),
    .req_ready(a_req_ready),
    .mem_w_en (a_mem_w_en),
    .addr     (a_addr),
    .wdata    (a_wdata),
    .rsp_valid(a_rsp_valid),
    .rdata    (a_rdata),
    .addr_err (a_addr_err),
    .stall    (a_stall)
  );

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .req_valid(z_req_valid),
    .req_ready(z_req_ready),
    .mem_w_en (z_mem_w_en),
    .addr     (z_addr),
    .wdata    (z_wdata),
    .rsp_valid(z_rsp_valid),
    .rdata    (z_rdata),
    .addr_err (z_addr_err),
    .stall    (z_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd1024);
  endfunction

  task automatic xact(input bit we, input logic [31:0] a,
                      input logic [31:0] d, input bit eerr,
                      input logic [31:0] erd, input bit chkd);
    int cyc;
    int lat;
    lat = eerr ? 1 : W + 2;
    @(negedge clk);
    a_req_valid = 1'b1;
    a_mem_w_en  = we;
    a_addr      = a;
    a_wdata     = d;
    #1;
    chk("acc_ready", a_req_ready, 1);
    chk("acc_stall", a_stall, !eerr);
    @(negedge clk);
    a_req_valid = 1'b0;
    #1;
    cyc = 1;
    while (!a_rsp_valid && cyc < 40) begin
      chk("busy_ready", a_req_ready, 0);
      chk("busy_stall", a_stall, 1);
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("latency", cyc, lat);
    chk("rsp_valid", a_rsp_valid, 1);
    chk("addr_err", a_addr_err, eerr);
    chk("rsp_stall", a_stall, 0);
    if (chkd) chk("rdata", a_rdata, erd);
    if (!eerr && we) m[a >> 2] = d;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    a_req_valid = 1'b0;
    a_mem_w_en  = 1'b0;
    a_addr      = '0;
    a_wdata     = '0;
    z_req_valid = 1'b0;
    z_mem_w_en  = 1'b0;
    z_addr      = '0;
    z_wdata     = '0;

    vt[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
    vt[2]  = '{1'b0, 32'h13,       32'h0,        1'b1, 32'h0};
    vt[3]  = '{1'b0, 32'h400,      32'h0,        1'b1, 32'h0};
    vt[4]  = '{1'b1, 32'h12,       32'h11111111, 1'b1, 32'h0};
    vt[5]  = '{1'b1, 32'h410,      32'h22222222, 1'b1, 32'h0};
    vt[6]  = '{1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
    vt[7]  = '{1'b1, 32'h20,       32'hA5A5A5A5, 1'b0, 32'h0};
    vt[8]  = '{1'b1, 32'h3FC,      32'h0BADF00D, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 32'h3FC,      32'h0,        1'b0, 32'h0BADF00D};
    vt[10] = '{1'b0, 32'h20,       32'h0,        1'b0, 32'hA5A5A5A5};
    vt[11] = '{1'b0, 32'h80000000, 32'h0,        1'b1, 32'h0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", a_req_ready, 1);
    chk("rst_stall", a_stall, 0);
    chk("rst_rsp", a_rsp_valid, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_err", a_addr_err, 0);

    foreach (vt[i])
      xact(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].eerr, vt[i].erd, 1'b1);

    // Zero wait states: store then load accepted in the first IDLE cycle.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      z_req_valid = (k == 0) || (k == 3);
      z_mem_w_en  = (k == 0);
      z_addr      = 32'h4;
      z_wdata     = 32'h1;
      #1;
      chk("w0_rsp", z_rsp_valid, (k == 2) || (k == 5));
      chk("w0_ready", z_req_ready, (k == 0) || (k == 3) || (k == 6));
      if (k == 2) chk("w0_st_rdata", z_rdata, 0);
      if (k == 5) chk("w0_ld_rdata", z_rdata, 32'h1);
    end
    z_req_valid = 1'b0;

    // Reset while a store sits in WAIT: it must be dropped.
    @(negedge clk);
    a_req_valid = 1'b1;
    a_mem_w_en  = 1'b1;
    a_addr      = 32'h20;
    a_wdata     = 32'hCAFEF00D;
    @(negedge clk);
    a_req_valid = 1'b0;
    #1;
    chk("pre_rst_stall", a_stall, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", a_req_ready, 1);
    chk("mid_rst_stall", a_stall, 0);
    chk("mid_rst_rsp", a_rsp_valid, 0);
    chk("mid_rst_rdata", a_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("post_rst_rsp", a_rsp_valid, 0);
      @(negedge clk);
    end
    xact(1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1);

    // Continuous requests: one accept and one response per W+3 cycles.
    for (int k = 0; k < 20; k++) begin
      logic [31:0] ea;
      @(negedge clk);
      a_req_valid = 1'b1;
      a_mem_w_en  = 1'b0;
      a_addr      = ((k / (W + 3)) % 2) ? 32'h20 : 32'h10;
      #1;
      chk("b2b_ready", a_req_ready, (k % (W + 3)) == 0);
      chk("b2b_rsp", a_rsp_valid, (k % (W + 3)) == W + 2);
      chk("b2b_stall", a_stall, (k % (W + 3)) != W + 2);
      if ((k % (W + 3)) == W + 2) begin
        ea = ((k / (W + 3)) % 2) ? 32'h20 : 32'h10;
        chk("b2b_rdata", a_rdata, m[ea >> 2]);
      end else begin
        chk("b2b_idle_rdata", a_rdata, 0);
      end
    end
    @(negedge clk);
    a_req_valid = 1'b0;

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [31:0] d;
      bit          we;
      bit          e;
      bit          known;
      a  = 32'h40 + 32'($urandom_range(0, 7)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(10, 31));
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      e  = is_err(a);
      known = e || we || m.exists(a >> 2);
      xact(we, a, d, e,
           (e || we) ? 32'h0 : (known ? m[a >> 2] : 32'h0), known);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
